sram_controller: RTL and testbench

Responder side of the data-memory interface driven by the MEM pipeline stage. It accepts a single 32-bit load or store per request and performs it on an external 16-bit asynchronous SRAM as two half-word accesses, each lasting a programmable number of wait cycles. It drives `ready` low until the access completes; the pipeline uses `!ready` as its freeze signal.

---
 rtl/sram_controller_pkg.sv | 20 ++
 rtl/sram_controller_wait_counter.sv | 36 +++
 rtl/sram_controller.sv | 117 +++++++++++
 tb/tb_sram_controller.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_controller_pkg.sv
// Shared widths, state encoding and the data-memory base offset for sram_controller.
// Address offset is enabled by defining MEM_ADDR_OFFSET_EN.
package sram_controller_pkg;

    localparam int WORD_WIDTH      = 32;
    localparam int SRAM_DATA_WIDTH = 16;
    localparam int SRAM_ADDR_WIDTH = 18;
    localparam int WORD_ADDR_WIDTH = SRAM_ADDR_WIDTH - 1;

    // Data memory is mapped at this byte address in the pipeline's view.
    localparam logic [WORD_WIDTH-1:0] MEM_ADDR_OFFSET = 32'd1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sram_controller_wait_counter.sv
// Clear/enable wait counter; tc flags the last cycle of a half-word access.
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign tc = (count_reg == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// MEM-stage data memory responder: one 32-bit access as two 16-bit async SRAM accesses.
// Define MEM_ADDR_OFFSET_EN to subtract the 1024-byte data memory base from address.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [WORD_WIDTH-1:0]      address,
    input  logic [WORD_WIDTH-1:0]      write_data,
    output logic [WORD_WIDTH-1:0]      read_data,
    output logic                       ready,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0] sram_dq_out,
    output logic                       sram_dq_oe,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_dq_in,
    output logic                       sram_we_n
);

    state_t                       state_reg;
    logic                         op_write_reg;
    logic [WORD_ADDR_WIDTH-1:0]   word_addr_reg;
    logic [SRAM_DATA_WIDTH-1:0]   wdata_hi_reg;
    logic [WORD_WIDTH-1:0]        eff_addr;
    logic [WORD_ADDR_WIDTH-1:0]   word_addr;
    logic                         request;
    logic                         busy;
    logic                         tc;
    logic                         unused_addr_bits;

`ifdef MEM_ADDR_OFFSET_EN
    assign eff_addr = address - MEM_ADDR_OFFSET;
`else
    assign eff_addr = address;
`endif

    // Byte lane bits and everything above the SRAM span are dropped, so addresses wrap.
    assign word_addr        = eff_addr[18:2];
    assign unused_addr_bits = ^{eff_addr[31:19], eff_addr[1:0]};

    assign request = wr_en | rd_en;
    assign busy    = (state_reg == ST_LOW) || (state_reg == ST_HIGH);
    assign ready   = (state_reg == ST_DONE) || ((state_reg == ST_IDLE) && !request);

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk (clk),
        .rst (rst),
        .clr (tc || !busy),
        .en  (busy),
        .tc  (tc)
    );

    // SRAM pins are loaded on the edge that enters each half so they are stable for all of it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            op_write_reg  <= 1'b0;
            word_addr_reg <= '0;
            wdata_hi_reg  <= '0;
            read_data     <= '0;
            sram_addr     <= '0;
            sram_dq_out   <= '0;
            sram_dq_oe    <= 1'b0;
            sram_we_n     <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (request) begin
                        op_write_reg  <= wr_en;
                        word_addr_reg <= word_addr;
                        wdata_hi_reg  <= write_data[31:16];
                        sram_addr     <= {word_addr, 1'b0};
                        if (wr_en) begin
                            sram_dq_out <= write_data[15:0];
                        end
                        sram_dq_oe    <= wr_en;
                        sram_we_n     <= ~wr_en;
                        state_reg     <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (tc) begin
                        if (!op_write_reg) begin
                            read_data[15:0] <= sram_dq_in;
                        end else begin
                            sram_dq_out <= wdata_hi_reg;
                        end
                        sram_addr <= {word_addr_reg, 1'b1};
                        state_reg <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (tc) begin
                        if (!op_write_reg) begin
                            read_data[31:16] <= sram_dq_in;
                        end
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                        state_reg  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: vector table plus reset, drop and back-to-back sequences.
`timescale 1ns/1ps
module tb_sram_controller;

    localparam int W0 = 2;
`ifdef MEM_ADDR_OFFSET_EN
    localparam logic [31:0] BASE = 32'd1024;
`else
    localparam logic [31:0] BASE = 32'd0;
`endif

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [17:0] exp_lo;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        mem_clr;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    logic        wr_en1, rd_en1;
    logic [31:0] address1, write_data1, read_data1;
    logic        ready1;
    logic [17:0] sram_addr1;
    logic [15:0] sram_dq_out1, sram_dq_in1;
    logic        sram_dq_oe1, sram_we_n1;

    logic [15:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    sram_controller #(.WAIT_CYCLES(W0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    sram_controller #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1),
        .address(address1), .write_data(write_data1), .read_data(read_data1),
        .ready(ready1), .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1),
        .sram_dq_oe(sram_dq_oe1), .sram_dq_in(sram_dq_in1), .sram_we_n(sram_we_n1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM shared by both controllers.
    assign sram_dq_in  = mem[sram_addr[9:0]];
    assign sram_dq_in1 = mem[sram_addr1[9:0]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else begin
            if (!sram_we_n && sram_dq_oe) mem[sram_addr[9:0]] <= sram_dq_out;
            if (!sram_we_n1 && sram_dq_oe1) mem[sram_addr1[9:0]] <= sram_dq_out1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request on dut at a negedge and follow it to DONE (bounded).
    task automatic do_access(input logic w, input logic r, input logic [31:0] a,
                             input logic [31:0] d, input int hold_cycles,
                             output int lat, output int we_cnt,
                             output logic [17:0] a_lo, output logic [17:0] a_hi,
                             output logic rdy0);
        @(negedge clk);
        wr_en = w; rd_en = r; address = a; write_data = d;
        #1;
        rdy0   = ready;
        lat    = 0;
        we_cnt = 0;
        a_lo   = '1;
        a_hi   = '1;
        while (lat < 40) begin
            @(negedge clk);
            #1;
            lat++;
            if (lat == hold_cycles) begin
                wr_en = 1'b0; rd_en = 1'b0; address = 32'hFFFF_FFFF; write_data = 32'h0;
            end
            if (!sram_we_n) we_cnt++;
            if (lat == 1) a_lo = sram_addr;
            if (lat == W0 + 1) a_hi = sram_addr;
            if (ready) break;
        end
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    vec_t vecs [10];

    initial begin
        int          lat, wec;
        logic [17:0] alo, ahi;
        logic        r0;

        vecs[0] = '{1'b1, 1'b0, BASE + 32'h10,    32'hDEADBEEF, 32'h00000000, 18'd8};
        vecs[1] = '{1'b0, 1'b1, BASE + 32'h10,    32'h0,        32'hDEADBEEF, 18'd8};
        vecs[2] = '{1'b1, 1'b1, BASE + 32'h20,    32'h12345678, 32'hDEADBEEF, 18'd16};
        vecs[3] = '{1'b0, 1'b1, BASE + 32'h20,    32'h0,        32'h12345678, 18'd16};
        vecs[4] = '{1'b0, 1'b1, BASE + 32'h13,    32'h0,        32'hDEADBEEF, 18'd8};
        vecs[5] = '{1'b1, 1'b0, BASE + 32'h80040, 32'hA5A55A5A, 32'hDEADBEEF, 18'd32};
        vecs[6] = '{1'b0, 1'b1, BASE + 32'h40,    32'h0,        32'hA5A55A5A, 18'd32};
        vecs[7] = '{1'b1, 1'b0, BASE + 32'h0,     32'hCAFEF00D, 32'hA5A55A5A, 18'd0};
        vecs[8] = '{1'b1, 1'b0, BASE + 32'h4,     32'h01234567, 32'hA5A55A5A, 18'd2};
        vecs[9] = '{1'b0, 1'b1, BASE + 32'h80004, 32'h0,        32'h01234567, 18'd2};

        rst = 1'b0; mem_clr = 1'b1;
        wr_en = 0; rd_en = 0; address = 0; write_data = 0;
        wr_en1 = 0; rd_en1 = 0; address1 = 0; write_data1 = 0;
        @(negedge clk);
        #1;
        chk("reset_ready",     32'(ready),       32'd1);
        chk("reset_read_data", read_data,        32'h0);
        chk("reset_sram_addr", 32'(sram_addr),   32'h0);
        chk("reset_dq_out",    32'(sram_dq_out), 32'h0);
        chk("reset_dq_oe",     32'(sram_dq_oe),  32'h0);
        chk("reset_we_n",      32'(sram_we_n),   32'h1);
        @(negedge clk);
        mem_clr = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, 100,
                      lat, wec, alo, ahi, r0);
            $display("access %0d: wr=%0b rd=%0b addr=%h wdata=%h lat=%0d rdata=%h",
                     i, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, lat, read_data);
            chk("vec_ready_cycle0", 32'(r0), 32'd0);
            chk("vec_latency", 32'(lat), 32'(2 * W0 + 1));
            chk("vec_we_cycles", 32'(wec), vecs[i].wr ? 32'd4 : 32'd0);
            chk("vec_addr_low", 32'(alo), 32'(vecs[i].exp_lo));
            chk("vec_addr_high", 32'(ahi), 32'(vecs[i].exp_lo + 18'd1));
            chk("vec_read_data", read_data, vecs[i].exp_rdata);
            if (vecs[i].wr) begin
                chk("vec_mem_low",  32'(mem[vecs[i].exp_lo[9:0]]),         32'(vecs[i].wdata[15:0]));
                chk("vec_mem_high", 32'(mem[vecs[i].exp_lo[9:0] + 10'd1]), 32'(vecs[i].wdata[31:16]));
            end
        end

        // Read whose request is dropped in cycle 2 still completes.
        do_access(1'b0, 1'b1, BASE + 32'h10, 32'h0, 2, lat, wec, alo, ahi, r0);
        $display("access drop: rd addr=%h lat=%0d rdata=%h", BASE + 32'h10, lat, read_data);
        chk("drop_latency",   32'(lat), 32'd5);
        chk("drop_read_data", read_data, 32'hDEADBEEF);

        // Reset asserted during the high half of a write.
        @(negedge clk);
        wr_en = 1'b1; address = BASE + 32'h30; write_data = 32'h11112222;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_we_in_high", 32'(sram_we_n), 32'd0);
        rst = 1'b0; wr_en = 1'b0;
        #1;
        $display("access abort: wr addr=%h reset in HIGH", BASE + 32'h30);
        chk("abort_we_n",      32'(sram_we_n),   32'd1);
        chk("abort_dq_oe",     32'(sram_dq_oe),  32'd0);
        chk("abort_sram_addr", 32'(sram_addr),   32'd0);
        chk("abort_dq_out",    32'(sram_dq_out), 32'd0);
        chk("abort_read_data", read_data,        32'd0);
        chk("abort_ready",     32'(ready),       32'd1);
        @(negedge clk);
        rst = 1'b1;
        chk("abort_mem_high_untouched", 32'(mem[25]), 32'd0);
        do_access(1'b1, 1'b0, BASE + 32'h30, 32'h33334444, 100, lat, wec, alo, ahi, r0);
        $display("access post-abort: wr addr=%h lat=%0d", BASE + 32'h30, lat);
        chk("post_latency",  32'(lat), 32'd5);
        chk("post_mem_low",  32'(mem[24]), 32'h4444);
        chk("post_mem_high", 32'(mem[25]), 32'h3333);
        do_access(1'b0, 1'b1, BASE + 32'h30, 32'h0, 100, lat, wec, alo, ahi, r0);
        $display("access post-abort: rd addr=%h lat=%0d rdata=%h", BASE + 32'h30, lat, read_data);
        chk("post_read_data", read_data, 32'h33334444);

        // WAIT_CYCLES=1: back-to-back reads, DONE in cycles 3 and 7.
        @(negedge clk);
        rd_en1 = 1'b1; address1 = BASE + 32'h0;
        #1;
        chk("w1_ready_c0", 32'(ready1), 32'd0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            #1;
            chk("w1_ready", 32'(ready1), (c == 3 || c == 7) ? 32'd1 : 32'd0);
            if (c == 1) chk("w1_addr_c1", 32'(sram_addr1), 32'd0);
            if (c == 2) chk("w1_addr_c2", 32'(sram_addr1), 32'd1);
            if (c == 5) chk("w1_addr_c5", 32'(sram_addr1), 32'd2);
            if (c == 6) chk("w1_addr_c6", 32'(sram_addr1), 32'd3);
            if (c == 3) begin
                $display("access w1 first: rd addr=%h rdata=%h", address1, read_data1);
                chk("w1_read0", read_data1, 32'hCAFEF00D);
                address1 = BASE + 32'h4;
            end
            if (c == 7) begin
                $display("access w1 second: rd addr=%h rdata=%h", address1, read_data1);
                chk("w1_read4", read_data1, 32'h01234567);
                rd_en1 = 1'b0;
            end
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
